// File: rtl/ldl_wrr_pkt_sched.sv
// ldl_wrr_pkt_sched
// Weighted round-robin packet scheduler. It multiplexes REQ_WIDTH input beat
// streams onto one output stream. A granted requester keeps the grant until
// its packet's last beat is accepted. Each requester may send up to weight[i]
// consecutive packets before the round-robin pointer moves past it.
//
// Ports:
//   clk       clock, all logic on the rising edge
//   rst       synchronous active-high reset
//   req       per-requester beat valid
//   last      per-requester end-of-packet flag (qualified by req)
//   data      per-requester beat payload, packed [REQ_WIDTH][DATA_WIDTH]
//   weight    per-requester packets per turn, packed [REQ_WIDTH][WGT_WIDTH];
//             0 behaves as 1
//   ready     downstream accepts the current beat
//   ack       one-hot beat pop to the granted requester
//   valid     output beat valid
//   out_data  output payload
//   out_last  output end-of-packet
//   bin       index of the granted requester
module ldl_wrr_pkt_sched #(
    parameter int BIN_WIDTH  = 3,
    parameter int REQ_WIDTH  = 1 << BIN_WIDTH,
    parameter int DATA_WIDTH = 8,
    parameter int WGT_WIDTH  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [REQ_WIDTH-1:0]                  req,
    input  logic [REQ_WIDTH-1:0]                  last,
    input  logic [REQ_WIDTH-1:0][DATA_WIDTH-1:0]  data,
    input  logic [REQ_WIDTH-1:0][WGT_WIDTH-1:0]   weight,
    input  logic                                  ready,
    output logic [REQ_WIDTH-1:0]                  ack,
    output logic                                  valid,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic                                  out_last,
    output logic [BIN_WIDTH-1:0]                  bin
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t                 state;
    logic [BIN_WIDTH-1:0]   ptr;
    logic [BIN_WIDTH-1:0]   cur;
    logic [WGT_WIDTH-1:0]   credit;
    logic                   hold;

    logic [BIN_WIDTH-1:0]   win;
    logic [BIN_WIDTH-1:0]   idx;
    logic                   found;
    logic [WGT_WIDTH-1:0]   wgt_win;
    logic [WGT_WIDTH-1:0]   credit_load;
    logic [WGT_WIDTH-1:0]   credit_n;
    logic                   xfer;
    logic                   eop;

    // Circular first-set search starting at ptr. REQ_WIDTH is a power of two,
    // so BIN_WIDTH-bit addition wraps REQ_WIDTH-1 -> 0 for free.
    always_comb begin
        win   = ptr;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            idx = ptr + BIN_WIDTH'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign wgt_win     = weight[win];
    assign credit_load = (wgt_win == '0) ? WGT_WIDTH'(1) : wgt_win;
    assign credit_n    = credit - WGT_WIDTH'(1);
    assign xfer        = (state == LOCK) && req[cur] && ready;
    assign eop         = xfer && last[cur];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            cur    <= '0;
            credit <= '0;
            hold   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        cur   <= win;
                        state <= LOCK;
                        // Only a returning held requester keeps its remaining
                        // credit; any other winner reloads and drops the hold.
                        if (!(hold && (win == cur))) begin
                            credit <= credit_load;
                            hold   <= 1'b0;
                        end
                    end
                end
                LOCK: begin
                    if (eop) begin
                        credit <= credit_n;
                        state  <= IDLE;
                        if (credit_n == '0) begin
                            ptr  <= cur + BIN_WIDTH'(1);
                            hold <= 1'b0;
                        end else begin
                            ptr  <= cur;
                            hold <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs pass straight through from the locked requester. They are forced
    // quiet during reset so a packet aborted by reset sees no ack that cycle.
    always_comb begin
        valid    = 1'b0;
        ack      = '0;
        out_data = '0;
        out_last = 1'b0;
        bin      = cur;
        if (rst) begin
            bin = '0;
        end else if (state == LOCK) begin
            valid    = req[cur];
            out_data = data[cur];
            out_last = last[cur];
            ack[cur] = req[cur] & ready;
        end
    end

endmodule

// File: tb/tb_ldl_wrr_pkt_sched.sv
module tb_ldl_wrr_pkt_sched;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      req;
    logic [7:0]      last;
    logic [7:0][7:0] data;
    logic [7:0][3:0] weight;
    logic            ready;
    logic [7:0]      ack;
    logic            valid;
    logic [7:0]      out_data;
    logic            out_last;
    logic [2:0]      bin;

    int checks   = 0;
    int failures = 0;
    int eb[8];

    always #5 clk = ~clk;

    ldl_wrr_pkt_sched #(
        .BIN_WIDTH (3),
        .REQ_WIDTH (8),
        .DATA_WIDTH(8),
        .WGT_WIDTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .last    (last),
        .data    (data),
        .weight  (weight),
        .ready   (ready),
        .ack     (ack),
        .valid   (valid),
        .out_data(out_data),
        .out_last(out_last),
        .bin     (bin)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        nxt();
        rst = 1'b0;
    endtask

    // Single-beat packets with req held: alternate idle cycle and grant cycle.
    task automatic run_pkts(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            sample();
            chk({tag, "_idle_valid"}, 32'(valid), 32'd0);
            chk({tag, "_idle_ack"}, 32'(ack), 32'd0);
            nxt();
            sample();
            chk({tag, "_bin"}, 32'(bin), 32'(eb[k]));
            chk({tag, "_valid"}, 32'(valid), 32'd1);
            chk({tag, "_ack"}, 32'(ack), 32'(8'd1 << eb[k]));
            chk({tag, "_data"}, 32'(out_data), 32'(eb[k] * 17));
            nxt();
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = 8'hff;
        last  = 8'hff;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data[i]   = 8'(i * 17);
            weight[i] = 4'd1;
        end

        // Reset held with all requesters active
        nxt();
        sample();
        chk("rst_valid_c1", 32'(valid), 32'd0);
        chk("rst_ack_c1", 32'(ack), 32'd0);
        chk("rst_bin_c1", 32'(bin), 32'd0);
        nxt();
        sample();
        chk("rst_valid_c2", 32'(valid), 32'd0);
        chk("rst_ack_c2", 32'(ack), 32'd0);
        chk("rst_bin_c2", 32'(bin), 32'd0);
        nxt();
        rst = 1'b0;
        sample();
        chk("post_rst_idle_valid", 32'(valid), 32'd0);
        nxt();
        sample();
        chk("first_grant_bin", 32'(bin), 32'd0);
        chk("first_grant_ack", 32'(ack), 32'h01);
        nxt();

        // Plain round-robin
        do_reset();
        req  = 8'ha5;
        last = 8'hff;
        eb   = '{0, 2, 5, 7, 0, 2, 0, 0};
        run_pkts(6, "rr");

        // Weighted
        do_reset();
        weight[0] = 4'd3;
        req       = 8'h03;
        eb        = '{0, 0, 0, 1, 0, 0, 0, 1};
        run_pkts(8, "wrr");
        weight[0] = 4'd1;

        // Multi-beat packet with backpressure, req1 waiting
        do_reset();
        req   = 8'h03;
        last  = 8'h00;
        ready = 1'b1;
        sample();
        chk("mb_idle_valid", 32'(valid), 32'd0);
        nxt();
        data[0] = 8'h11;
        sample();
        chk("mb_b1_bin", 32'(bin), 32'd0);
        chk("mb_b1_ack", 32'(ack), 32'h01);
        chk("mb_b1_data", 32'(out_data), 32'h11);
        chk("mb_b1_last", 32'(out_last), 32'd0);
        nxt();
        data[0] = 8'h22;
        ready   = 1'b0;
        sample();
        chk("mb_stall_valid", 32'(valid), 32'd1);
        chk("mb_stall_ack", 32'(ack), 32'h00);
        chk("mb_stall_data", 32'(out_data), 32'h22);
        chk("mb_stall_bin", 32'(bin), 32'd0);
        nxt();
        ready = 1'b1;
        sample();
        chk("mb_b2_ack", 32'(ack), 32'h01);
        chk("mb_b2_data", 32'(out_data), 32'h22);
        nxt();
        data[0] = 8'h33;
        last    = 8'h01;
        sample();
        chk("mb_b3_ack", 32'(ack), 32'h01);
        chk("mb_b3_last", 32'(out_last), 32'd1);
        chk("mb_b3_data", 32'(out_data), 32'h33);
        nxt();
        last = 8'hff;
        sample();
        chk("mb_gap_valid", 32'(valid), 32'd0);
        chk("mb_gap_ack", 32'(ack), 32'h00);
        nxt();
        sample();
        chk("mb_next_bin", 32'(bin), 32'd1);
        chk("mb_next_ack", 32'(ack), 32'h02);
        nxt();
        data[0] = 8'h00;

        // Hold dropped when the held requester goes away
        do_reset();
        weight[2] = 4'd4;
        req       = 8'h04;
        eb        = '{2, 0, 0, 0, 0, 0, 0, 0};
        run_pkts(1, "hd_first");
        req = 8'h20;
        eb  = '{5, 0, 0, 0, 0, 0, 0, 0};
        run_pkts(1, "hd_other");
        req = 8'h24;
        eb  = '{2, 2, 2, 2, 5, 0, 0, 0};
        run_pkts(5, "hd_reload");
        weight[2] = 4'd1;

        // Reset in the middle of a multi-beat packet
        do_reset();
        req  = 8'h04;
        last = 8'hff;
        eb   = '{2, 0, 0, 0, 0, 0, 0, 0};
        run_pkts(1, "mr_pre");
        req  = 8'h09;
        last = 8'h00;
        nxt();
        sample();
        chk("mr_b1_bin", 32'(bin), 32'd3);
        chk("mr_b1_ack", 32'(ack), 32'h08);
        nxt();
        rst = 1'b1;
        sample();
        chk("mr_rst_valid", 32'(valid), 32'd0);
        chk("mr_rst_ack", 32'(ack), 32'h00);
        nxt();
        rst = 1'b0;
        sample();
        chk("mr_after_valid", 32'(valid), 32'd0);
        chk("mr_after_ack", 32'(ack), 32'h00);
        nxt();
        sample();
        chk("mr_regrant_bin", 32'(bin), 32'd0);
        chk("mr_regrant_ack", 32'(ack), 32'h01);
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ldl_wrr_pkt_sched.md
Name: ldl_wrr_pkt_sched

Overview:
- Weighted round-robin packet scheduler. Multiplexes REQ_WIDTH input beat streams onto one output stream.
- Once a requester is granted, the grant stays locked until its packet's last beat is accepted.
- Each requester may send up to weight[i] consecutive packets before the round-robin pointer advances.
- Sits in front of a shared egress resource, such as a DMA write port or a serializer.

Parameters:
- BIN_WIDTH, 3, width of requester index.
- REQ_WIDTH, 1<<BIN_WIDTH, number of requesters.
- DATA_WIDTH, 8, beat payload width.
- WGT_WIDTH, 4, per-requester weight width.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  REQ_WIDTH  per-requester beat valid.
- last  input  REQ_WIDTH  per-requester end-of-packet flag, qualified by req.
- data  input  REQ_WIDTH x DATA_WIDTH  per-requester beat payload (packed 2-D).
- weight  input  REQ_WIDTH x WGT_WIDTH  packets per turn; 0 is treated as 1.
- ready  input  1  downstream accepts the beat.
- ack  output  REQ_WIDTH  one-hot beat pop to the granted requester.
- valid  output  1  output beat valid.
- out_data  output  DATA_WIDTH  output payload.
- out_last  output  1  output end-of-packet.
- bin  output  BIN_WIDTH  index of the granted requester.

Behaviour:
- Reset:
  - Internal state: state=IDLE, ptr=0, cur=0, credit=0, hold=0.
  - Outputs: valid=0, ack=0, out_last=0, out_data=0, bin=0.
  - A reset asserted mid-packet aborts the packet; no ack is issued in the reset cycle.
- FSM, two states: IDLE and LOCK.
- IDLE:
  - valid=0, ack=0.
  - If req!=0, winner g = first set bit of req, searching circularly from ptr upward (wrap REQ_WIDTH-1 -> 0).
  - Register cur=g and go to LOCK.
  - If req==0, remain in IDLE.
- Credit load on grant:
  - If hold=1 and g==cur, keep the current credit.
  - Otherwise credit = (weight[g]==0) ? 1 : weight[g].
  - weight is sampled only at grant time; changes during LOCK have no effect.
- LOCK (combinational pass-through):
  - valid=req[cur], out_data=data[cur], out_last=last[cur], bin=cur.
  - ack[cur]=req[cur]&ready; all other ack bits are 0.
  - A beat is transferred when valid&ready.
- End of packet (transfer with out_last=1):
  - credit_n = credit-1.
  - If credit_n==0: ptr=(cur+1) mod REQ_WIDTH, hold=0.
  - Else: ptr=cur, hold=1.
  - credit=credit_n; next state is IDLE.
- Latency and throughput:
  - Grant is visible one cycle after req is seen in IDLE.
  - There is exactly one idle cycle between consecutive packets.
  - Within a packet, one beat per cycle when req and ready are both high.
- req[cur] low during LOCK: valid=0 and the lock is held indefinitely (no timeout, no preemption).
- Held requester absent in IDLE: if hold=1 but req[cur]=0, the search starts from ptr=cur, so another requester wins. That requester's credit is reloaded, which drops the old hold.
- ready low: the beat stalls and outputs remain stable while req[cur] stays high.
- Inputs of non-granted requesters are ignored; their ack is always 0.

Test Plan:
- Reset: rst=1 for 2 cycles with req=0xff -> valid=0, ack=0, bin=0 throughout. First grant after release is bin=0.
- Round-robin: req=0xa5, last=0xff, weight all 1, ready=1 -> bin sequence 0,2,5,7,0,2. valid on alternate cycles; ack one-hot matches bin.
- Weighted: weight[0]=3, weight[1]=1, req=0x03 single-beat -> bin 0,0,0,1,0,0,0,1.
- Multi-beat with backpressure: req0 sends a 3-beat packet (last on beat 3), req1 held high, ready=1,0,1,1 -> bin stays 0. ack[0] is high only when ready=1. ack[1]=0 until the cycle after beat 3 is accepted, then bin=1.
- Hold drop: weight[2]=4, req2 sends 1 packet then deasserts, req5 high -> next grant bin=5. When req2 returns after req5's packet, credit is reloaded to 4 (four consecutive req2 packets).
- Reset mid-packet: rst=1 during beat 2 of a 4-beat packet from req3 -> next cycle valid=0 and ack=0. After release, the grant search restarts from ptr=0.
